tdm_mux_scan: RTL

//  Parametrised, registered N:1 multiplexer with valid/ready flow control.

---
 rtl/tdm_mux_pkg.sv | 16 +
 rtl/tdm_mux_ptr.sv | 29 ++
 rtl/tdm_mux_scan.sv | 98 +++++++++
 3 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared encodings for the TDM multiplexer: FSM state and mode-pin values.
package tdm_mux_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } tdm_state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic tdm_state_e mode_to_state(input logic m);
    return (m == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
  endfunction

endpackage

// File: rtl/tdm_mux_ptr.sv
// Modulo-CHANNELS counter with enable and synchronous load-to-zero.
// Wraps on an explicit compare, so non-power-of-two channel counts work.
module tdm_mux_ptr #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load0,
  output logic [SEL_W-1:0] o_ptr
);

  localparam logic [SEL_W-1:0] LP_LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (i_load0)
      r_ptr <= '0;
    else if (i_en)
      r_ptr <= (r_ptr == LP_LAST) ? '0 : r_ptr + SEL_W'(1);
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/tdm_mux_scan.sv
// Registered N:1 multiplexer with valid/ready. MANUAL forwards channel sel;
// SCAN round-robins one slot per channel and tags each word with its source.
module tdm_mux_scan
  import tdm_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0] LP_NCH = (SEL_W+1)'(CHANNELS);

  tdm_state_e          r_state;
  logic                r_valid;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_chan;

  logic [SEL_W-1:0]    w_ptr;
  logic [SEL_W-1:0]    w_cand;
  logic                w_slot_free;
  logic                w_cand_ok;
  logic                w_go;
  logic                w_take;
  logic                w_ptr_en;
  logic                w_ptr_load0;
  logic [CHANNELS-1:0] w_ready;
  logic [WIDTH-1:0]    w_mux;

  assign w_slot_free = !r_valid || out_ready;
  assign w_cand      = (r_state == ST_SCAN) ? w_ptr : sel;
  // An out-of-range manual select simply has no candidate.
  assign w_cand_ok   = (r_state == ST_SCAN) || ({1'b0, sel} < LP_NCH);
  assign w_go        = !rst && w_slot_free && w_cand_ok;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_rdy
    assign w_ready[k] = w_go && (w_cand == SEL_W'(k)) && in_valid[k];
  end

  assign w_take   = |w_ready;
  assign in_ready = w_ready;

  always_comb begin
    w_mux = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (w_ready[k]) w_mux = in_data[k*WIDTH +: WIDTH];
  end

  // Pointer walks every free slot in SCAN, valid or not, so each channel
  // gets exactly one slot per CHANNELS cycles; entering SCAN restarts at 0.
  assign w_ptr_en    = (r_state == ST_SCAN) && w_slot_free;
  assign w_ptr_load0 = (r_state == ST_MANUAL) && (mode == MODE_SCAN);

  tdm_mux_ptr #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_ptr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ptr_en),
    .i_load0 (w_ptr_load0),
    .o_ptr   (w_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MANUAL;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
    end else begin
      r_state <= mode_to_state(mode);
      if (w_take) begin
        r_valid <= 1'b1;
        r_data  <= w_mux;
        r_chan  <= w_cand;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule
